// File: rtl/spi_reg_responder.sv
// spi_reg_responder
//   SPI mode-0 slave register file using the accelerometer command framing:
//   an instruction byte (0x0B read, 0x0A write), an address byte, then any
//   number of data bytes with address auto-increment (wrapping mod NUM_REGS).
//   Local logic loads registers through the host port; every SPI-written byte
//   is reported with a one-clk strobe.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   sclk, csn     SPI clock / chip select from the master (asynchronous)
//   mosi, miso    SPI data in / out, MSB first
//   host_we       host register write enable (one register per clk)
//   host_addr     host write index
//   host_wdata    host write data
//   wr_strobe     one-clk pulse per SPI-written byte
//   wr_addr       index of the last SPI-written byte (holds between strobes)
//   wr_data       last SPI-written byte (holds between strobes)
//   busy          high while a transaction is in progress
module spi_reg_responder #(
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclk,
   input  logic                  csn,
   input  logic                  mosi,
   output logic                  miso,
   input  logic                  host_we,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [7:0]            host_wdata,
   output logic                  wr_strobe,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [7:0]            wr_data,
   output logic                  busy
);

   localparam int NUM_REGS = 2**ADDR_WIDTH;

   typedef enum logic [2:0] {
      IDLE, INSTR, ADDR, DATA_RD, DATA_WR, IGNORE
   } state_t;

   state_t state, state_nxt;

   logic sclk_p0, sclk_p1, sclk_p2;
   logic csn_p0, csn_p1, csn_p2;
   logic mosi_p0, mosi_p1;
   logic rise_p3, fall_p3, csn_fall_p3, csn_high_p3, mosi_p3;

   logic [2:0]            bit_cnt;
   logic [6:0]            rx_shift;
   logic [7:0]            rx_byte;
   logic                  byte_done;
   logic                  rd;
   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH-1:0] addr_inc;
   logic [7:0]            tx_shift;
   logic [7:0]            regs [NUM_REGS];

   // Stage p0/p1: two-flop synchronizers. Stage p2/p3: edge detection, with
   // the detected events registered so mosi stays aligned with its sclk rise.
   // The csn chain resets low so a csn held low across reset cannot look like
   // a falling edge; only a genuine high-to-low transition starts a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_p0     <= 1'b0;
         sclk_p1     <= 1'b0;
         sclk_p2     <= 1'b0;
         csn_p0      <= 1'b0;
         csn_p1      <= 1'b0;
         csn_p2      <= 1'b0;
         mosi_p0     <= 1'b0;
         mosi_p1     <= 1'b0;
         rise_p3     <= 1'b0;
         fall_p3     <= 1'b0;
         csn_fall_p3 <= 1'b0;
         csn_high_p3 <= 1'b0;
         mosi_p3     <= 1'b0;
      end else begin
         sclk_p0     <= sclk;
         sclk_p1     <= sclk_p0;
         sclk_p2     <= sclk_p1;
         csn_p0      <= csn;
         csn_p1      <= csn_p0;
         csn_p2      <= csn_p1;
         mosi_p0     <= mosi;
         mosi_p1     <= mosi_p0;
         rise_p3     <= sclk_p1 & ~sclk_p2;
         fall_p3     <= ~sclk_p1 & sclk_p2;
         csn_fall_p3 <= ~csn_p1 & csn_p2;
         csn_high_p3 <= csn_p1;
         mosi_p3     <= mosi_p1;
      end
   end

   assign rx_byte   = {rx_shift, mosi_p3};
   assign byte_done = rise_p3 && (bit_cnt == 3'd7);
   assign addr_inc  = addr + ADDR_WIDTH'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
      end
   end

   always_comb begin
      state_nxt = state;
      if (csn_high_p3) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (csn_fall_p3) state_nxt = INSTR;
            INSTR:   if (byte_done) begin
                        if (rx_byte == 8'h0B || rx_byte == 8'h0A) state_nxt = ADDR;
                        else                                       state_nxt = IGNORE;
                     end
            ADDR:    if (byte_done) state_nxt = rd ? DATA_RD : DATA_WR;
            default: state_nxt = state;
         endcase
      end
   end

   // Stage p4: byte assembly, register file, miso and write reporting.
   // The SPI write is placed after the host write so it wins a same-index
   // collision in the same clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt   <= '0;
         rx_shift  <= '0;
         rd        <= 1'b0;
         addr      <= '0;
         tx_shift  <= '0;
         miso      <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         wr_strobe <= 1'b0;
         if (host_we) regs[host_addr] <= host_wdata;

         if (csn_high_p3) begin
            // A partial byte is simply dropped here.
            bit_cnt <= '0;
            miso    <= 1'b0;
         end else begin
            if (rise_p3 && state != IDLE) begin
               bit_cnt  <= bit_cnt + 3'd1;
               rx_shift <= rx_byte[6:0];
            end
            if (byte_done) begin
               case (state)
                  INSTR: rd <= (rx_byte == 8'h0B);
                  ADDR: begin
                     addr     <= rx_byte[ADDR_WIDTH-1:0];
                     tx_shift <= regs[rx_byte[ADDR_WIDTH-1:0]];
                  end
                  DATA_RD: begin
                     addr     <= addr_inc;
                     tx_shift <= regs[addr_inc];
                  end
                  DATA_WR: begin
                     regs[addr] <= rx_byte;
                     wr_strobe  <= 1'b1;
                     wr_addr    <= addr;
                     wr_data    <= rx_byte;
                     addr       <= addr_inc;
                  end
                  default: ;
               endcase
            end
            // tx_shift is a snapshot taken at byte completion, so host writes
            // to that index do not disturb the byte already being shifted out.
            if (fall_p3 && state == DATA_RD) begin
               miso     <= tx_shift[7];
               tx_shift <= {tx_shift[6:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_responder.sv
// tb_spi_reg_responder
//   Directed bench for spi_reg_responder acting as an SPI mode-0 master with a
//   register model; expected read bytes and write strobes are queued when the
//   stimulus is issued and compared when the DUT returns them.
module tb_spi_reg_responder;

   localparam int HALF = 8;   // sclk half period in clk cycles

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk = 1'b0;
   logic       csn = 1'b1;
   logic       mosi = 1'b0;
   logic       miso;
   logic       host_we = 1'b0;
   logic [5:0] host_addr = '0;
   logic [7:0] host_wdata = '0;
   logic       wr_strobe;
   logic [5:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;

   spi_reg_responder #(.ADDR_WIDTH(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .sclk       (sclk),
      .csn        (csn),
      .mosi       (mosi),
      .miso       (miso),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .wr_strobe  (wr_strobe),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int         n_total = 0;
   int         n_pass  = 0;
   logic [7:0] model [64];
   logic [7:0] exp_rd [$];
   logic [5:0] exp_wa [$];
   logic [7:0] exp_wd [$];
   logic [5:0] obs_wa [$];
   logic [7:0] obs_wd [$];
   int         obs_idx = 0;
   logic [7:0] col_data = '0;
   logic [5:0] col_addr = '0;

   // Strobe monitor: records every SPI write the DUT reports.
   always @(negedge clk) begin
      if (wr_strobe === 1'b1) begin
         obs_wa.push_back(wr_addr);
         obs_wd.push_back(wr_data);
      end
   end

   initial begin
      #500us;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
   endtask

   task automatic host_write(input logic [5:0] a, input logic [7:0] d);
      @(negedge clk);
      host_we = 1'b1; host_addr = a; host_wdata = d;
      @(negedge clk);
      host_we = 1'b0;
      model[a] = d;
   endtask

   task automatic spi_byte(input logic [7:0] tx, input int nbits, input logic col,
                           output logic [7:0] rx);
      rx = '0;
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = tx[i];
         repeat (HALF) @(negedge clk);
         rx[i] = miso;
         sclk = 1'b1;
         if (col && i == 0) begin
            // Host write lands in the same clk as the SPI byte write.
            repeat (3) @(negedge clk);
            host_we = 1'b1; host_addr = col_addr; host_wdata = col_data;
            @(negedge clk);
            host_we = 1'b0;
            chk("strobe_latency", wr_strobe, 1'b1);
            repeat (HALF - 4) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         sclk = 1'b0;
      end
   endtask

   task automatic spi_start();
      @(negedge clk);
      csn = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic spi_end();
      repeat (HALF) @(negedge clk);
      csn = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask

   task automatic spi_read(input logic [7:0] a, input int n);
      logic [7:0] rx;
      logic [5:0] idx;
      for (int k = 0; k < n; k++) begin
         idx = a[5:0] + 6'(k);
         exp_rd.push_back(model[idx]);
      end
      spi_start();
      spi_byte(8'h0B, 8, 1'b0, rx);
      spi_byte(a, 8, 1'b0, rx);
      chk("busy_in_read", busy, 1'b1);
      for (int k = 0; k < n; k++) begin
         spi_byte(8'h00, 8, 1'b0, rx);
         chk($sformatf("read_%02h_byte%0d", a, k), rx, exp_rd.pop_front());
      end
      spi_end();
      chk("busy_after_read", busy, 1'b0);
   endtask

   task automatic check_strobes(input string tag);
      int n;
      int guard;
      n = exp_wa.size();
      guard = 0;
      while (obs_wa.size() < obs_idx + n && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, "_strobe_count"}, obs_wa.size(), obs_idx + n);
      while (exp_wa.size() > 0) begin
         if (obs_idx < obs_wa.size()) begin
            chk({tag, "_wr_addr"}, obs_wa[obs_idx], exp_wa[0]);
            chk({tag, "_wr_data"}, obs_wd[obs_idx], exp_wd[0]);
         end
         obs_idx++;
         void'(exp_wa.pop_front());
         void'(exp_wd.pop_front());
      end
      obs_idx = obs_wa.size();
   endtask

   task automatic spi_write(input logic [7:0] a, input int n, input logic [7:0] d0,
                            input logic [7:0] d1, input logic col);
      logic [7:0] rx;
      logic [5:0] idx;
      logic [7:0] d;
      spi_start();
      spi_byte(8'h0A, 8, 1'b0, rx);
      spi_byte(a, 8, 1'b0, rx);
      for (int k = 0; k < n; k++) begin
         d   = (k == 0) ? d0 : d1;
         idx = a[5:0] + 6'(k);
         exp_wa.push_back(idx);
         exp_wd.push_back(d);
         model[idx] = d;
         spi_byte(d, 8, col && (k == 0), rx);
      end
      spi_end();
   endtask

   initial begin
      logic [7:0] rx;
      for (int i = 0; i < 64; i++) model[i] = 8'h00;

      // Reset state
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_miso", miso, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_wr_strobe", wr_strobe, 1'b0);
      chk("rst_wr_addr", wr_addr, 6'h00);
      chk("rst_wr_data", wr_data, 8'h00);

      // 1: host-loaded registers read back over SPI, no strobe
      host_write(6'h0E, 8'hA5);
      host_write(6'h0F, 8'h3C);
      spi_read(8'h0E, 2);
      check_strobes("t1");

      // 2: SPI burst write, strobes, readback
      spi_write(8'h20, 2, 8'h11, 8'h22, 1'b0);
      check_strobes("t2");
      spi_read(8'h20, 2);
      chk("wr_addr_hold", wr_addr, 6'h21);
      chk("wr_data_hold", wr_data, 8'h22);

      // 3: address wrap and dropped upper address bits
      host_write(6'h3F, 8'h5A);
      host_write(6'h00, 8'h77);
      spi_read(8'h3F, 2);
      spi_read(8'hCE, 1);

      // 4: unknown instruction is ignored
      spi_start();
      spi_byte(8'h0C, 8, 1'b0, rx);
      for (int k = 0; k < 3; k++) begin
         spi_byte(8'hFF, 8, 1'b0, rx);
         chk($sformatf("ignore_miso_byte%0d", k), rx, 8'h00);
      end
      chk("ignore_busy", busy, 1'b1);
      spi_end();
      chk("ignore_busy_after", busy, 1'b0);
      check_strobes("t4");
      spi_read(8'h0F, 1);

      // 5: aborted partial byte, then host/SPI collision
      host_write(6'h10, 8'h99);
      spi_start();
      spi_byte(8'h0A, 8, 1'b0, rx);
      spi_byte(8'h10, 8, 1'b0, rx);
      spi_byte(8'hFF, 4, 1'b0, rx);
      spi_end();
      check_strobes("t5_partial");
      spi_read(8'h10, 1);
      col_addr = 6'h05;
      col_data = 8'hC3;
      spi_write(8'h05, 1, 8'h5C, 8'h00, 1'b1);
      check_strobes("t5_collide");
      spi_read(8'h05, 1);

      // 6: reset in the middle of a read
      spi_start();
      spi_byte(8'h0B, 8, 1'b0, rx);
      spi_byte(8'h0E, 8, 1'b0, rx);
      spi_byte(8'h00, 3, 1'b0, rx);
      chk("pre_rst_miso", miso, 1'b1);
      rst = 1'b1;
      #1;
      chk("midrst_miso", miso, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_wr_strobe", wr_strobe, 1'b0);
      chk("midrst_wr_data", wr_data, 8'h00);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 64; i++) model[i] = 8'h00;
      repeat (2) @(negedge clk);
      csn = 1'b1;
      repeat (2 * HALF) @(negedge clk);
      chk("post_rst_busy", busy, 1'b0);
      spi_read(8'h0E, 1);
      spi_read(8'h20, 2);
      check_strobes("t6");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
